// File: rtl/bcd_score_counter.sv
// Multi-digit BCD up/down score counter with ripple carry/borrow, wrap or
// saturate overflow handling, new-round clear and session high-score tracking.
module bcd_score_counter #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    inc,
  input  logic                    dec,
  input  logic [3:0]              step,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [4*NUM_DIGITS-1:0] high_score,
  output logic                    carry_out,
  output logic                    borrow_out,
  output logic                    is_zero,
  output logic                    new_high
);

  localparam int unsigned W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0] bcd_q, bcd_d;
  logic [W-1:0] high_q, high_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         new_high_q, new_high_d;

  logic [3:0]   step_sat;
  logic [W-1:0] add_res, sub_res;
  logic         add_cy, sub_bw;
  logic [4:0]   dsum, need, digit;

  // Single-cycle ripple add and subtract; only digit 0 sees the step value.
  always_comb begin
    step_sat = (step > 4'd9) ? 4'd9 : step;
    add_res  = '0;
    sub_res  = '0;
    add_cy   = 1'b0;
    sub_bw   = 1'b0;
    dsum     = '0;
    need     = '0;
    digit    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = 5'(bcd_q[4*i +: 4]);
      dsum  = digit + ((i == 0) ? 5'(step_sat) : 5'd0) + 5'(add_cy);
      if (dsum > 5'd9) begin
        add_res[4*i +: 4] = 4'(dsum - 5'd10);
        add_cy            = 1'b1;
      end else begin
        add_res[4*i +: 4] = dsum[3:0];
        add_cy            = 1'b0;
      end
      need = ((i == 0) ? 5'(step_sat) : 5'd0) + 5'(sub_bw);
      if (digit >= need) begin
        sub_res[4*i +: 4] = 4'(digit - need);
        sub_bw            = 1'b0;
      end else begin
        sub_res[4*i +: 4] = 4'(digit + 5'd10 - need);
        sub_bw            = 1'b1;
      end
    end
  end

  // Next-state: clear > (inc xor dec) > hold; high score tracks independently.
  always_comb begin
    bcd_d      = bcd_q;
    high_d     = high_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    new_high_d = 1'b0;

    // Packed BCD with MSD on top compares numerically as plain unsigned.
    if (bcd_q > high_q) begin
      high_d     = bcd_q;
      new_high_d = 1'b1;
    end

    if (clear) begin
      bcd_d = '0;
    end else if ((inc ^ dec) && (step_sat != 4'd0)) begin
      if (inc) begin
        carry_d = add_cy;
        bcd_d   = (add_cy && SATURATE) ? ALL_NINES : add_res;
      end else begin
        borrow_d = sub_bw;
        bcd_d    = (sub_bw && SATURATE) ? '0 : sub_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q      <= '0;
      high_q     <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      high_q     <= high_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      new_high_q <= new_high_d;
    end
  end

  assign bcd        = bcd_q;
  assign high_score = high_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign new_high   = new_high_q;
  assign is_zero    = (bcd_q == '0);

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
- Parametrised multi-digit BCD up/down score counter. It is the next generation of the game's per-digit score state machines.
- One instance holds the whole score: NUM_DIGITS BCD digits with ripple carry/borrow between digits.
- Supports a per-event point step (1-9), a wrap or saturate mode, and a synchronous clear.
- Tracks a session high score. Outputs feed the seg7 decoders directly, one nibble per display.

Parameters:
- NUM_DIGITS, 3, number of BCD digits; legal range 1-6.
- SATURATE, 1, 1 = clamp at 0 and at all-nines; 0 = modulo-10^NUM_DIGITS wrap.

Ports:
- clk  input  1  game clock (difficulty-scaled).
- reset  input  1  central reset; clears score and high score.
- clear  input  1  new-round clear; zeroes score only.
- inc  input  1  add step points this cycle.
- dec  input  1  subtract step points this cycle.
- step  input  4  point value, binary 0-15; values above 9 are treated as 9.
- bcd  output  4*NUM_DIGITS  current score; digit i is at [4i+3:4i], digit 0 = ones.
- high_score  output  4*NUM_DIGITS  highest score held since reset.
- carry_out  output  1  one-cycle pulse on an increment that would exceed all-nines.
- borrow_out  output  1  one-cycle pulse on a decrement that would go below zero.
- is_zero  output  1  1 when bcd == 0 (combinational from the register).
- new_high  output  1  one-cycle pulse on the cycle high_score is updated.

Behaviour:
- Reset state: all outputs are registered except is_zero. On reset, bcd = 0, high_score = 0, carry_out = 0, borrow_out = 0, new_high = 0. Consequently is_zero = 1.
- Priority at each posedge: reset > clear > (inc XOR dec) > hold.
- clear: sets bcd = 0 and leaves high_score untouched. carry_out and borrow_out are 0 on that edge.
- inc and dec both high: score holds, no pulses.
- step = 0: score holds, no pulses.
- Increment datapath:
  - Digit 0 gets digit + s, where s = min(step, 9).
  - Each digit result > 9 subtracts 10 and passes carry 1 to the next digit; upper digits add only the incoming carry.
  - The whole add completes in one cycle; the new bcd is visible the cycle after inc is sampled.
- Decrement datapath:
  - Digit 0 gets digit - s.
  - Each digit result < 0 adds 10 and passes borrow 1 upward.
- Overflow (carry out of the top digit):
  - carry_out = 1 for exactly one cycle, aligned with the bcd update.
  - SATURATE = 1: bcd becomes all-nines.
  - SATURATE = 0: bcd keeps the wrapped value (e.g. 998 + 5 = 003).
- Underflow (borrow out of the top digit):
  - borrow_out = 1 for exactly one cycle.
  - SATURATE = 1: bcd becomes 0.
  - SATURATE = 0: bcd keeps the wrapped value (e.g. 002 - 5 = 997).
- Saturated hold: with bcd already all-nines (SATURATE = 1), each further inc with nonzero step pulses carry_out again and bcd stays all-nines. Zero with dec behaves the same way via borrow_out.
- No illegal digits: every digit of bcd and high_score is always 0-9.
- High score:
  - Compare the registered bcd against high_score each cycle; the comparison is numeric, i.e. unsigned BCD, most significant digit first.
  - If bcd > high_score, the next edge loads high_score <= bcd and pulses new_high for one cycle.
  - high_score therefore lags bcd by one cycle.
  - clear on the same edge does not block a pending high_score update.
- Reset mid-operation: reset wins on the same edge as inc/dec/clear. All pulses are 0 on the following cycle.

Test Plan:
- Reset: reset = 1 for 2 cycles -> bcd = 000, high_score = 000, is_zero = 1, all pulses 0.
- Ripple carry: SATURATE = 0, count from 000 with inc, step = 1 for 10 cycles -> bcd = 010. Then inc, step = 9 from 095 -> bcd = 104, carry_out stays 0.
- Wrap: SATURATE = 0. From 998, inc step = 5 -> bcd = 003, carry_out = 1 for one cycle. From 002, dec step = 5 -> bcd = 997, borrow_out = 1 for one cycle.
- Saturation: SATURATE = 1. From 997, inc step = 7 -> bcd = 999, carry_out = 1; another inc -> bcd = 999, carry_out = 1. From 003, dec step = 9 -> bcd = 000, borrow_out = 1, is_zero = 1.
- Controls: inc = dec = 1 with step = 4 -> bcd unchanged. step = 14 at bcd = 010 -> bcd = 019 (clamped to 9). clear with inc at 250 -> bcd = 000.
- High score: raise score to 120 -> high_score = 120 one cycle later with new_high pulse. Then clear and count to 050 -> high_score stays 120, no new_high. Then reach 121 -> high_score = 121 with new_high.
